instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
- Upstream neighbour of instruction_decoder.
- Accepts the host instruction stream as narrow HOST_DATA_WIDTH beats and assembles them into full INSTRUCTION_WIDTH instruction words.
- Queues assembled words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Decouples host write bursts from decoder/issue stalls.

Parameters:
- OPCODE_WIDTH, 8, opcode field width
- FLAG_WIDTH, 8, flags field width
- LENGTH_WIDTH, 8, length field width
- HOST_MEMORY_ADDRESS_WIDTH, 64, host address field width
- LOCAL_MEMORY_ADDRESS_WIDTH, 24, local address field width
- HOST_DATA_WIDTH, 32, width of one host beat
- FIFO_DEPTH, 8, instruction slots; power of two, >=2
- INSTRUCTION_WIDTH (localparam), sum of the five field widths = 112
- BEATS (localparam), ceil(INSTRUCTION_WIDTH/HOST_DATA_WIDTH) = 4

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of FIFO and partial assembly
- host_wdata  in  HOST_DATA_WIDTH  instruction beat, LSB beat first
- host_wvalid  in  1  beat valid
- host_wready  out  1  beat accepted when host_wvalid && host_wready
- instr_data  out  INSTRUCTION_WIDTH  head-of-FIFO instruction, to decoder
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  decoder consumes head when instr_valid && instr_ready
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied slots

Behaviour:
- Interface: one clock domain, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, async), all outputs and state:
  - beat_cnt=0, assembly register=0, wr_ptr=rd_ptr=0, fifo_count=0
  - instr_valid=0, host_wready=1, instr_data=0
  - Reset mid-assembly discards the partial instruction. FIFO memory contents need no reset; instr_data must still read 0 while empty after reset.
- Beat assembly:
  - Beat k (k=0..BEATS-1) fills bits [k*HDW +: HDW] of the instruction.
  - Bits above INSTRUCTION_WIDTH-1 in the last beat are ignored.
  - beat_cnt increments on each accepted beat and wraps BEATS-1 -> 0.
- Field packing, MSB to LSB: opcode[111:104], flags[103:96], length[95:88], host_addr[87:24], local_addr[23:0].
- Push timing:
  - On the accepted last beat, the full instruction (prior beats plus current beat) is written to FIFO[wr_ptr] at that edge.
  - No extra register stage is inserted.
  - Then wr_ptr+1 mod FIFO_DEPTH and fifo_count+1.
- host_wready = (beat_cnt != BEATS-1) || (fifo_count != FIFO_DEPTH).
  - Non-final beats are always accepted.
  - host_wready has no combinational path from instr_ready.
- Pop:
  - On instr_valid && instr_ready, rd_ptr+1 mod FIFO_DEPTH and fifo_count-1.
  - instr_data = FIFO[rd_ptr], combinational read of registered storage.
  - instr_valid = (fifo_count != 0).
- Latency: last beat accepted at edge N -> instr_valid=1 and instr_data valid after edge N, when the FIFO was empty.
- Simultaneous push and pop in one cycle: fifo_count unchanged and both pointers advance. This is legal at any occupancy 1..FIFO_DEPTH-1. At full, a push cannot occur because host_wready=0 on the last beat.
- Pop when empty: ignored. instr_ready is don't-care when instr_valid=0.
- Pointers: log2(FIFO_DEPTH) bits with natural wrap; full/empty are derived from fifo_count only.
- flush=1 (synchronous, highest priority):
  - Next edge sets beat_cnt=0, pointers=0, fifo_count=0.
  - A beat presented in the same cycle is dropped.
  - A pop in the same cycle is ignored.
  - host_wready=1 after the flush edge.
- instr_data while instr_valid=0: don't-care except immediately after reset.

Decomposition:
- Package tpu_isa_pkg:
  - field width constants
  - INSTRUCTION_WIDTH
  - packed struct instruction_t {opcode, flags, length, host_addr, local_addr} in the MSB-to-LSB order above
  - shared by this block and instruction_decoder
- Sub-module sync_fifo:
  - parameters WIDTH, DEPTH
  - ports push/pop/flush, count, async active-low reset
  - reusable elsewhere in the core
- Assembler counter and register stay in instr_fetch_buffer.

Test Plan:
- Reset: assert rst_n=0 mid-beat-2 -> instr_valid=0, fifo_count=0, host_wready=1, instr_data=0; the next four beats form a clean new instruction.
- Single instruction: beats 0x7789ABCD, 0x33445566, 0x56001122, 0xFFFF1234 -> instr_valid after the 4th edge, instr_data=0x1234_5600_1122_3344_5566_7789_ABCD (opcode 0x12, flags 0x34, length 0x56, host 0x0011223344556677, local 0x89ABCD).
- Backpressure: instr_ready=0, push 8 instructions -> fifo_count=8; beats 0-2 of a 9th accepted, beat 3 held with host_wready=0; one pop -> beat 3 accepted next cycle, count returns to 8.
- Concurrent push/pop at fifo_count=3: last beat accepted plus pop in the same cycle -> count stays 3, FIFO order preserved (check sequence IDs).
- Flush with 2 queued instructions and beat_cnt=2 -> after the edge count=0, instr_valid=0; a subsequent 4-beat instruction is output intact.
- Wrap-around: stream 20 instructions with random instr_ready -> output order and data match the scoreboard and fifo_count never exceeds 8.

Source files
------------

// File: rtl/tpu_isa_pkg.sv
// Shared TPU instruction format: field widths and packed instruction layout.
// Used by the fetch buffer and the instruction decoder.
package tpu_isa_pkg;

    localparam int unsigned OPCODE_WIDTH               = 8;
    localparam int unsigned FLAG_WIDTH                 = 8;
    localparam int unsigned LENGTH_WIDTH               = 8;
    localparam int unsigned HOST_MEMORY_ADDRESS_WIDTH  = 64;
    localparam int unsigned LOCAL_MEMORY_ADDRESS_WIDTH = 24;

    localparam int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + FLAG_WIDTH + LENGTH_WIDTH
                                              + HOST_MEMORY_ADDRESS_WIDTH
                                              + LOCAL_MEMORY_ADDRESS_WIDTH;

    // MSB to LSB: opcode, flags, length, host_addr, local_addr.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]               opcode;
        logic [FLAG_WIDTH-1:0]                 flags;
        logic [LENGTH_WIDTH-1:0]               length;
        logic [HOST_MEMORY_ADDRESS_WIDTH-1:0]  host_addr;
        logic [LOCAL_MEMORY_ADDRESS_WIDTH-1:0] local_addr;
    } instruction_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous flush and async active-low reset.
// Read data is a combinational view of the head slot, forced to zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; the empty mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Assembles narrow host beats (LSB beat first) into full instruction words and queues
// them for the decoder behind a valid/ready handshake.
module instr_fetch_buffer #(
    parameter int unsigned OPCODE_WIDTH               = 8,
    parameter int unsigned FLAG_WIDTH                 = 8,
    parameter int unsigned LENGTH_WIDTH               = 8,
    parameter int unsigned HOST_MEMORY_ADDRESS_WIDTH  = 64,
    parameter int unsigned LOCAL_MEMORY_ADDRESS_WIDTH = 24,
    parameter int unsigned HOST_DATA_WIDTH            = 32,
    parameter int unsigned FIFO_DEPTH                 = 8,
    localparam int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + FLAG_WIDTH + LENGTH_WIDTH
                                              + HOST_MEMORY_ADDRESS_WIDTH
                                              + LOCAL_MEMORY_ADDRESS_WIDTH,
    localparam int unsigned BEATS = (INSTRUCTION_WIDTH + HOST_DATA_WIDTH - 1) / HOST_DATA_WIDTH,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [HOST_DATA_WIDTH-1:0]   host_wdata,
    input  logic                         host_wvalid,
    output logic                         host_wready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [CNT_W-1:0]             fifo_count
);

    import tpu_isa_pkg::*;

    localparam int unsigned HDW    = HOST_DATA_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
    // Holds beats 0..BEATS-2; the final beat goes straight from the bus into the FIFO.
    logic [(BEATS-1)*HDW-1:0]  asm_q, asm_d;
    logic [BEATS*HDW-1:0]      full_word;
    logic                      last_beat;
    logic                      beat_acc;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign last_beat   = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign host_wready = !last_beat || !fifo_full;
    assign beat_acc    = host_wvalid && host_wready && !flush;
    assign push        = beat_acc && last_beat;
    assign pop         = instr_valid && instr_ready;
    assign full_word   = {host_wdata, asm_q};

    if (BEATS * HDW > INSTRUCTION_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^full_word[BEATS*HDW-1:INSTRUCTION_WIDTH];
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        if (flush) begin
            beat_cnt_d = '0;
            asm_d      = '0;
        end else if (beat_acc) begin
            if (last_beat) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                for (int k = 0; k < int'(BEATS) - 1; k++) begin
                    if (beat_cnt_q == BEAT_W'(k)) begin
                        asm_d[k*HDW +: HDW] = host_wdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_q      <= asm_d;
        end
    end

    sync_fifo #(
        .WIDTH (INSTRUCTION_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (full_word[INSTRUCTION_WIDTH-1:0]),
        .pop       (pop),
        .pop_data  (instr_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomized bench for instr_fetch_buffer against a queue-based reference model.
module tb_instr_fetch_buffer;

    import tpu_isa_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  host_wdata = '0;
    logic         host_wvalid = 1'b0;
    logic         host_wready;
    logic [111:0] instr_data;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [3:0]   fifo_count;

    always #5 clk = ~clk;

    instr_fetch_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .host_wdata  (host_wdata),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fifo_count  (fifo_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queued words, beats collected so far, and the partial word.
    logic [111:0] mq[$];
    int           mbeat;
    logic [127:0] mpart;
    bit           last_acc;
    int           max_count;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_wready();
        return (mbeat != 3) || (mq.size() != 8);
    endfunction

    task automatic model_reset();
        mq.delete();
        mbeat = 0;
        mpart = '0;
    endtask

    function automatic logic [111:0] rand_instr(input logic [7:0] id);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return {id, r[103:0]};
    endfunction

    // Compare outputs mid-cycle, advance the model with the current inputs, cross the edge.
    task automatic cycle();
        bit acc;
        @(negedge clk);
        check_eq("valid", instr_valid, mq.size() != 0);
        check_eq("count", fifo_count, mq.size());
        check_eq("wready", host_wready, m_wready());
        if (mq.size() != 0) check_eq("data", instr_data, mq[0]);
        if (fifo_count > max_count) max_count = fifo_count;
        last_acc = 1'b0;
        if (flush) begin
            model_reset();
        end else begin
            acc = host_wvalid && m_wready();
            if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
            if (acc) begin
                last_acc = 1'b1;
                mpart[mbeat*32 +: 32] = host_wdata;
                if (mbeat == 3) begin
                    mq.push_back(mpart[111:0]);
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] data);
        int n;
        n = 0;
        host_wvalid = 1'b1;
        host_wdata  = data;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check_eq("beat_timeout", 0, 1);
        host_wvalid = 1'b0;
    endtask

    task automatic send_instr(input logic [111:0] w);
        logic [15:0] pad;
        for (int k = 0; k < 3; k++) send_beat(w[k*32 +: 32]);
        pad = 16'($urandom);
        send_beat({pad, w[111:96]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        instr_ready = 1'b1;
        while (mq.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        instr_ready = 1'b0;
        check_eq("drain_empty", fifo_count, 0);
    endtask

    initial begin
        logic [111:0] w;
        instruction_t ins;
        int n;
        int beats_in;

        model_reset();
        max_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_wready", host_wready, 1);
        check_eq("rst_data", instr_data, 0);
        rst_n = 1'b1;

        // Single instruction from fixed beats.
        send_beat(32'h7789ABCD);
        send_beat(32'h33445566);
        send_beat(32'h56001122);
        send_beat(32'hFFFF1234);
        check_eq("single_valid", instr_valid, 1);
        check_eq("single_data", instr_data, 112'h1234_5600_1122_3344_5566_7789_ABCD);
        ins = instruction_t'(instr_data);
        check_eq("single_opcode", ins.opcode, 8'h12);
        check_eq("single_flags", ins.flags, 8'h34);
        check_eq("single_length", ins.length, 8'h56);
        check_eq("single_host", ins.host_addr, 64'h0011223344556677);
        check_eq("single_local", ins.local_addr, 24'h89ABCD);
        drain();

        // Async reset with one word queued and two beats of the next assembled.
        send_instr(rand_instr(8'hA0));
        send_beat(32'hDEAD0001);
        send_beat(32'hDEAD0002);
        host_wvalid = 1'b1;
        host_wdata  = 32'hDEAD0003;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", instr_valid, 0);
        check_eq("arst_count", fifo_count, 0);
        check_eq("arst_wready", host_wready, 1);
        check_eq("arst_data", instr_data, 0);
        model_reset();
        host_wvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w = rand_instr(8'hA1);
        send_instr(w);
        check_eq("arst_clean_data", instr_data, w);
        drain();

        // Backpressure: fill, hold the final beat of a ninth word, release with one pop.
        for (int i = 0; i < 8; i++) send_instr(rand_instr(8'(i)));
        check_eq("bp_full_count", fifo_count, 8);
        w = rand_instr(8'h08);
        for (int k = 0; k < 3; k++) send_beat(w[k*32 +: 32]);
        host_wvalid = 1'b1;
        host_wdata  = {16'h0, w[111:96]};
        cycle();
        check_eq("bp_hold_wready", host_wready, 0);
        check_eq("bp_hold_acc", last_acc, 0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        cycle();
        check_eq("bp_release_acc", last_acc, 1);
        check_eq("bp_refill_count", fifo_count, 8);
        host_wvalid = 1'b0;
        drain();

        // Concurrent push and pop at occupancy 3.
        for (int i = 0; i < 3; i++) send_instr(rand_instr(8'(8'h10 + i)));
        w = rand_instr(8'h13);
        for (int k = 0; k < 3; k++) send_beat(w[k*32 +: 32]);
        host_wvalid = 1'b1;
        host_wdata  = {16'h0, w[111:96]};
        instr_ready = 1'b1;
        cycle();
        host_wvalid = 1'b0;
        instr_ready = 1'b0;
        check_eq("pp_count", fifo_count, 3);
        check_eq("pp_head_id", instr_data[111:104], 8'h11);
        drain();

        // Flush with two queued words and a half-assembled third.
        send_instr(rand_instr(8'h20));
        send_instr(rand_instr(8'h21));
        send_beat(32'h0BAD0000);
        send_beat(32'h0BAD0001);
        flush       = 1'b1;
        host_wvalid = 1'b1;
        host_wdata  = 32'h0BAD0002;
        instr_ready = 1'b1;
        cycle();
        flush       = 1'b0;
        host_wvalid = 1'b0;
        instr_ready = 1'b0;
        check_eq("flush_count", fifo_count, 0);
        check_eq("flush_valid", instr_valid, 0);
        check_eq("flush_wready", host_wready, 1);
        w = rand_instr(8'h22);
        send_instr(w);
        check_eq("flush_after_data", instr_data, w);
        check_eq("flush_after_count", fifo_count, 1);
        drain();

        // Random stream of 20 instructions with random gaps and random decoder stalls.
        beats_in  = 0;
        n         = 0;
        max_count = 0;
        while ((beats_in < 80 || mq.size() != 0) && n < 3000) begin
            host_wvalid = (beats_in < 80) && ($urandom_range(3) != 0);
            host_wdata  = $urandom;
            instr_ready = 1'($urandom_range(1));
            cycle();
            if (last_acc) beats_in++;
            n++;
        end
        host_wvalid = 1'b0;
        instr_ready = 1'b0;
        check_eq("rand_done", (beats_in == 80) && (mq.size() == 0), 1);
        check_eq("rand_max_count_le8", max_count <= 8, 1);
        check_eq("rand_final_count", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
